// File: rtl/confreg_lite.sv
`default_nettype none
// ============================================================================
//  Module      : confreg_lite
//  Description : CPU data-SRAM responder. A word-addressed data RAM, plus a
//                small register window holding LED, SWITCH, TIMER, NUM and
//                SCRATCH registers. Every cycle is one access; read data is
//                registered (1-cycle latency, read-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module confreg_lite #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] C_OFF_LED     = 16'hf000;
    localparam logic [15:0] C_OFF_SWITCH  = 16'hf010;
    localparam logic [15:0] C_OFF_TIMER   = 16'hf020;
    localparam logic [15:0] C_OFF_NUM     = 16'hf030;
    localparam logic [15:0] C_OFF_SCRATCH = 16'hf040;
    localparam int          C_DEPTH       = 1 << RAM_AW;

    // Byte-lane bits are not part of the word index.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, data_sram_addr[1:0]};

    logic              w_conf_hit;
    logic [15:0]       w_offset;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_reg_we;

    assign w_conf_hit = (data_sram_addr[31:16] == CONF_BASE);
    assign w_offset   = data_sram_addr[15:0];
    assign w_ram_idx  = data_sram_addr[RAM_AW+1:2];
    assign w_reg_we   = data_sram_we && w_conf_hit;

    logic [31:0] mem_q [0:C_DEPTH-1];
    logic [15:0] led_q;
    logic [31:0] timer_q, timer_d;
    logic [31:0] num_q;
    logic [31:0] scratch_q;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] rdata_q;
    logic [31:0] w_reg_rdata;

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        w_reg_rdata = 32'h0;
        case (w_offset)
            C_OFF_LED:     w_reg_rdata = {16'h0, led_q};
            C_OFF_SWITCH:  w_reg_rdata = {24'h0, sw_sync_q};
            C_OFF_TIMER:   w_reg_rdata = timer_q;
            C_OFF_NUM:     w_reg_rdata = num_q;
            C_OFF_SCRATCH: w_reg_rdata = scratch_q;
            default:       w_reg_rdata = 32'h0;
        endcase
    end

    // Timer next state: a write loads, otherwise free-running increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (w_reg_we && (w_offset == C_OFF_TIMER))
            timer_d = data_sram_wdata;
    end

    // Data RAM: no reset on contents, writes suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!reset && data_sram_we && !w_conf_hit)
            mem_q[w_ram_idx] <= data_sram_wdata;
    end

    // Registered read data; old contents are sampled before same-edge writes.
    always_ff @(posedge clk) begin
        if (reset)
            rdata_q <= 32'h0;
        else if (w_conf_hit)
            rdata_q <= w_reg_rdata;
        else
            rdata_q <= mem_q[w_ram_idx];
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Writable configuration registers and the free-running timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= 16'h0;
            timer_q   <= 32'h0;
            num_q     <= 32'h0;
            scratch_q <= 32'h0;
        end else begin
            timer_q <= timer_d;
            if (w_reg_we && (w_offset == C_OFF_LED))
                led_q <= data_sram_wdata[15:0];
            if (w_reg_we && (w_offset == C_OFF_NUM))
                num_q <= data_sram_wdata;
            if (w_reg_we && (w_offset == C_OFF_SCRATCH))
                scratch_q <= data_sram_wdata;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule
`default_nettype wire
